// File: rtl/fml_ddr3_bist_if.sv
// FML bus bundle between an initiator and the DDR3 FML responder.
interface fml_if #(
    parameter int adr_width = 30
);
    logic [adr_width-1:0] fml_adr;
    logic                 fml_stb;
    logic                 fml_we;
    logic                 fml_ack;
    logic [7:0]           fml_sel;
    logic [63:0]          fml_do;
    logic [63:0]          fml_di;

    modport master (
        output fml_adr, fml_stb, fml_we, fml_sel, fml_do,
        input  fml_ack, fml_di
    );

    modport slave (
        input  fml_adr, fml_stb, fml_we, fml_sel, fml_do,
        output fml_ack, fml_di
    );
endinterface

// File: rtl/fml_ddr3_bist.sv
// FML memory self-test master: writes an address-derived pattern in
// 4-beat bursts over a region, reads it back and counts mismatches.
module fml_ddr3_bist #(
    parameter int adr_width = 30,
    parameter int cnt_width = 20,
    parameter int timeout   = 1024
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 start,
    input  logic [adr_width-1:0] base_adr,
    input  logic [cnt_width-1:0] nbursts,
    input  logic [31:0]          seed,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout_err,
    output logic [15:0]          err_count,
    output logic [adr_width-1:0] first_err_adr,
    fml_if.master                fml
);
    localparam int TW = $clog2(timeout + 1);

    typedef enum logic [2:0] {
        IDLE, WR_REQ, WR_DATA, RD_REQ, RD_DATA, DONE
    } state_t;

    state_t               state_q, state_d;
    logic [adr_width-1:0] base_q, base_d;
    logic [adr_width-1:0] adr_q, adr_d;
    logic [adr_width-1:0] ferr_q, ferr_d;
    logic [cnt_width-1:0] nb_q, nb_d;
    logic [cnt_width-1:0] cnt_q, cnt_d;
    logic [31:0]          seed_q, seed_d;
    logic [1:0]           beat_q, beat_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic [15:0]          err_q, err_d;
    logic                 terr_q, terr_d;

    logic [adr_width-1:0] beat_adr;
    logic [31:0]          x;
    logic [63:0]          exp_w;
    logic                 wr_st, req, last_burst, tmo_hit;

    // Expected word for the beat currently on the bus
    assign beat_adr   = adr_q + adr_width'({beat_q, 3'b000});
    assign x          = 32'(beat_adr) ^ seed_q;
    assign exp_w      = {x, ~x};
    assign wr_st      = (state_q == WR_REQ) || (state_q == WR_DATA);
    assign req        = (state_q == WR_REQ) || (state_q == RD_REQ);
    assign last_burst = (cnt_q == nb_q - 1'b1);
    assign tmo_hit    = req && !fml.fml_ack && (tmo_q == TW'(timeout - 1));

    assign fml.fml_adr = adr_q;
    assign fml.fml_stb = req;
    assign fml.fml_we  = wr_st;
    assign fml.fml_sel = wr_st ? 8'hFF : 8'h00;
    assign fml.fml_do  = wr_st ? exp_w : 64'h0;

    assign busy          = (state_q != IDLE) && (state_q != DONE);
    assign done          = (state_q == DONE);
    assign pass          = done && (err_q == 16'h0) && !terr_q;
    assign timeout_err   = terr_q;
    assign err_count     = err_q;
    assign first_err_adr = ferr_q;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        adr_d   = adr_q;
        ferr_d  = ferr_q;
        nb_d    = nb_q;
        cnt_d   = cnt_q;
        seed_d  = seed_q;
        beat_d  = beat_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        terr_d  = terr_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    base_d  = {base_adr[adr_width-1:5], 5'b0};
                    adr_d   = {base_adr[adr_width-1:5], 5'b0};
                    nb_d    = nbursts;
                    seed_d  = seed;
                    cnt_d   = '0;
                    beat_d  = '0;
                    tmo_d   = '0;
                    err_d   = '0;
                    terr_d  = 1'b0;
                    ferr_d  = '0;
                    state_d = (nbursts == '0) ? DONE : WR_REQ;
                end
            end
            WR_REQ, RD_REQ: begin
                if (fml.fml_ack) begin
                    tmo_d   = '0;
                    beat_d  = (state_q == WR_REQ) ? 2'd1 : 2'd0;
                    state_d = (state_q == WR_REQ) ? WR_DATA : RD_DATA;
                end else if (tmo_hit) begin
                    terr_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            WR_DATA: begin
                beat_d = beat_q + 1'b1;
                if (beat_q == 2'd3) begin
                    if (last_burst) begin
                        adr_d   = base_q;
                        cnt_d   = '0;
                        state_d = RD_REQ;
                    end else begin
                        adr_d   = adr_q + adr_width'(32);
                        cnt_d   = cnt_q + 1'b1;
                        state_d = WR_REQ;
                    end
                end
            end
            RD_DATA: begin
                beat_d = beat_q + 1'b1;
                if (fml.fml_di != exp_w) begin
                    if (err_q != 16'hFFFF) err_d = err_q + 1'b1;
                    if (err_q == 16'h0) ferr_d = beat_adr;
                end
                if (beat_q == 2'd3) begin
                    adr_d   = adr_q + adr_width'(32);
                    cnt_d   = cnt_q + 1'b1;
                    state_d = last_burst ? DONE : RD_REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            adr_q   <= '0;
            ferr_q  <= '0;
            nb_q    <= '0;
            cnt_q   <= '0;
            seed_q  <= '0;
            beat_q  <= '0;
            tmo_q   <= '0;
            err_q   <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            adr_q   <= adr_d;
            ferr_q  <= ferr_d;
            nb_q    <= nb_d;
            cnt_q   <= cnt_d;
            seed_q  <= seed_d;
            beat_q  <= beat_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            terr_q  <= terr_d;
        end
    end
endmodule

// File: doc/fml_ddr3_bist.md
Name: fml_ddr3_bist

Overview:
- FML initiator (master) that exercises the DDR3 FML port: writes a deterministic address-derived pattern over a region in 4-beat bursts, then reads the region back and compares.
- Sits beside the CPU/DMA masters on the FML arbiter, or is wired directly to the DDR3 FML port for board bring-up after phy_init_done.
- Reports pass/fail, mismatch count, first failing address and ack timeouts.

Parameters:
- adr_width, 30, FML byte-address width.
- cnt_width, 20, width of the burst-count input.
- timeout, 1024, sys_clk cycles to wait for fml_ack before aborting.

Ports:
- sys_clk  in  1  system clock, all logic on rising edge.
- sys_rst  in  1  reset; asynchronous assert, active-high.
- start  in  1  one-cycle pulse; samples config; ignored unless state=IDLE or DONE.
- base_adr  in  adr_width  region start byte address; bits [4:0] treated as 0.
- nbursts  in  cnt_width  number of 32-byte bursts to test.
- seed  in  32  pattern seed.
- busy  out  1  high from cycle after accepted start until DONE.
- done  out  1  high in DONE, cleared by next accepted start.
- pass  out  1  valid when done: no mismatch and no timeout.
- timeout_err  out  1  set if any request waits > timeout cycles for ack.
- err_count  out  16  mismatching 64-bit words, saturating at 16'hFFFF.
- first_err_adr  out  adr_width  byte address of first mismatching word.
- fml_adr  out  adr_width  burst address, [4:0]=0.
- fml_stb  out  1  request strobe.
- fml_we  out  1  1=write burst, 0=read burst.
- fml_ack  in  1  responder accepts the request.
- fml_sel  out  8  byte enables; 8'hFF during write beats, 8'h00 otherwise.
- fml_do  out  64  write data to responder.
- fml_di  in  64  read data from responder.

Behaviour:
- Reset values: fml_stb=0, fml_we=0, fml_adr=0, fml_sel=0, fml_do=0, busy=0, done=0, pass=0, timeout_err=0, err_count=0, first_err_adr=0, state=IDLE.
- Pattern: for byte address w (zero-extended to 32 bits), x = w ^ seed; data = {x, ~x}. Beat b of a burst at A uses w = A + 8*b.
- FML protocol, request:
  - Master holds fml_stb, fml_adr and fml_we stable until the cycle fml_ack=1.
  - fml_stb deasserts the cycle after ack.
  - Next request is issued no earlier than the cycle after the last data beat.
- FML protocol, write data:
  - Beat 0 is on fml_do/fml_sel from stb assertion; the responder samples it in the ack cycle.
  - Beats 1..3 follow on the next 3 cycles.
  - fml_sel returns to 0 after beat 3.
- FML protocol, read data: beat 0 is valid on fml_di the cycle after ack; beats 1..3 on the following 3 cycles.
- States and transitions:
  - IDLE: on start → WR_REQ. Latch base_adr (with [4:0]=0), nbursts and seed. Clear done, pass, err_count, timeout_err, first_err_adr and the burst counter.
  - If the latched nbursts=0: go straight to DONE with pass=1; no FML traffic.
  - WR_REQ: stb=1, we=1. On ack → WR_DATA, beat counter=1.
  - WR_DATA: drive beats 1..3. After beat 3: if bursts remain → WR_REQ at next address (+32); else → RD_REQ at base.
  - RD_REQ: stb=1, we=0. On ack → RD_DATA.
  - RD_DATA: compare 4 consecutive beats against expected.
    - On each mismatch: increment err_count (saturating).
    - On the first mismatch only: load first_err_adr.
    - After beat 3: → RD_REQ at next address, or DONE when all bursts are read.
  - DONE: busy=0, done=1, pass = (err_count==0 && !timeout_err). start → IDLE actions, i.e. restart.
- Address wrap-around: addresses increment modulo 2^adr_width; wrap is not an error.
- Timeout:
  - A counter runs while stb=1 without ack.
  - On reaching `timeout`: drop stb, set timeout_err, → DONE (pass=0).
  - An ack arriving in the same cycle the counter expires takes priority: the burst proceeds and no timeout is flagged.
- Simultaneous events: start while busy is ignored. fml_ack while stb=0 is ignored.
- Reset mid-burst: all outputs return to reset values asynchronously. The responder is expected to be reset by the same sys_rst.

Test Plan:
- Reset: assert sys_rst mid-write burst → fml_stb=0, busy=0, done=0, err_count=0 the same cycle, asynchronously.
- Clean run: ideal 4-beat memory model with ack latency 3; base=0x100, nbursts=2, seed=0.
  - Expect 2 write bursts at 0x100 and 0x120; first beat data = 64'h00000100_FFFFFEFF.
  - Then 2 read bursts; done=1, pass=1, err_count=0.
- Injected fault: memory model flips bit 0 of the word at 0x128 on read; base=0x100, nbursts=2, seed=0xA5A5A5A5.
  - Expect err_count=1, first_err_adr=0x128, pass=0.
- Timeout: responder never acks, timeout=16 → stb high exactly 16 cycles, then timeout_err=1, done=1, pass=0.
- Zero length: nbursts=0 → done=1, pass=1 within 2 cycles; fml_stb never asserted.
- Wrap and restart:
  - base=2^30−32, nbursts=2 → second burst at address 0, pass=1.
  - A start pulse while busy is ignored.
  - A start pulse in DONE relaunches the test and clears the status outputs.
